// File: rtl/sreg_deser_if.sv
// sreg_deser_if -- stream/control bundle for the serial-to-parallel collector.
//   clr       : synchronous flush of partial word, buffer and sticky flags
//   in_vld    : in_sym qualifier
//   in_sym    : incoming WIDTH-bit symbol, least-significant symbol first
//   out_vld   : buffer head holds a word
//   out_rdy   : consumer accepts the head word this cycle
//   out_word  : buffer head word (0 when empty)
//   busy      : partial frame in progress
//   ovf       : sticky, a completed word was dropped on a full buffer
//   perr      : sticky parity error (parity build only, else 0)
// Modports: master = upstream producer/consumer side, slave = collector.
interface sreg_deser_if #(
  parameter int N     = 4,
  parameter int WIDTH = 1
);
  logic                 clr;
  logic                 in_vld;
  logic [WIDTH-1:0]     in_sym;
  logic                 out_vld;
  logic                 out_rdy;
  logic [N*WIDTH-1:0]   out_word;
  logic                 busy;
  logic                 ovf;
  logic                 perr;

  modport master (
    output clr, in_vld, in_sym, out_rdy,
    input  out_vld, out_word, busy, ovf, perr
  );

  modport slave (
    input  clr, in_vld, in_sym, out_rdy,
    output out_vld, out_word, busy, ovf, perr
  );
endinterface

// File: rtl/sreg_deser.sv
// sreg_deser -- rebuilds N-symbol words from a qualified symbol stream and
// presents them through a 2-entry valid/ready holding buffer.
// Ports:
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset
//   bus   : sreg_deser_if.slave (clr, in_vld/in_sym, out_vld/out_rdy/out_word,
//           busy, ovf, perr)
// Build option: define SREG_DESER_PARITY_EN to append one even-parity symbol
// to every frame; mismatching words are discarded and perr is set.
module sreg_deser #(
  parameter int N     = 4,
  parameter int WIDTH = 1
) (
  input  logic            clk,
  input  logic            rstn,
  sreg_deser_if.slave     bus
);

  localparam int DW = N * WIDTH;
`ifdef SREG_DESER_PARITY_EN
  localparam int FRAME = N + 1;
  // Whole data word is kept so it can be checked against the parity slot.
  localparam int AW    = DW;
`else
  localparam int FRAME = N;
  // Last symbol of the frame is taken straight from in_sym, so only N-1
  // symbols need to be stored.
  localparam int AW    = DW - WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  logic [CW-1:0]  r_cnt;
  logic [AW-1:0]  r_acc;
  logic [DW-1:0]  r_mem [2];
  logic           r_head;
  logic           r_tail;
  logic [1:0]     r_occ;
  logic           r_ovf;
`ifdef SREG_DESER_PARITY_EN
  logic           r_perr;
`endif

  logic           w_last;
  logic           w_done;
  logic           w_par_ok;
  logic           w_push;
  logic           w_pop;
  logic           w_room;
  logic           w_wr;
  logic [AW-1:0]  w_shift;
  logic [DW-1:0]  w_word;

  always_comb begin
    w_last   = (r_cnt == CW'(FRAME - 1));
    w_done   = bus.in_vld && w_last;
    w_pop    = (r_occ != 2'd0) && bus.out_rdy;
    w_shift  = {bus.in_sym, r_acc[AW-1:WIDTH]};
`ifdef SREG_DESER_PARITY_EN
    // On the parity slot the accumulator already holds the full data word.
    w_word   = r_acc;
    w_par_ok = (bus.in_sym[0] == ^r_acc);
`else
    w_word   = {bus.in_sym, r_acc};
    w_par_ok = 1'b1;
`endif
    w_push   = w_done && w_par_ok;
    // A full buffer still accepts a push when the head leaves the same cycle.
    w_room   = (r_occ != 2'd2) || w_pop;
    w_wr     = w_push && w_room;
  end

  always_ff @(posedge clk) begin
    if (!rstn || bus.clr) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_occ    <= 2'd0;
      r_ovf    <= 1'b0;
`ifdef SREG_DESER_PARITY_EN
      r_perr   <= 1'b0;
`endif
    end else begin
      if (bus.in_vld) begin
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        r_acc <= w_shift;
      end
      if (w_wr) begin
        r_mem[r_tail] <= w_word;
        r_tail        <= ~r_tail;
      end
      if (w_push && !w_room) r_ovf <= 1'b1;
`ifdef SREG_DESER_PARITY_EN
      if (w_done && !w_par_ok) r_perr <= 1'b1;
`endif
      if (w_pop) r_head <= ~r_head;
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.out_vld  = (r_occ != 2'd0);
  assign bus.out_word = (r_occ != 2'd0) ? r_mem[r_head] : '0;
  assign bus.busy     = (r_cnt != '0);
  assign bus.ovf      = r_ovf;
`ifdef SREG_DESER_PARITY_EN
  assign bus.perr     = r_perr;
`else
  assign bus.perr     = 1'b0;
`endif

endmodule

// File: tb/tb_sreg_deser.sv
// tb_sreg_deser -- directed scenarios plus randomized traffic for sreg_deser,
// checked every cycle against a queue-based behavioural model.
module tb_sreg_deser;

  localparam int N     = 4;
  localparam int WIDTH = 1;
  localparam int DW    = N * WIDTH;
`ifdef SREG_DESER_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sreg_deser_if #(.N(N), .WIDTH(WIDTH)) bus();

  sreg_deser #(.N(N), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: symbols of the frame in progress, words waiting in the buffer.
  logic [WIDTH-1:0] m_syms [$];
  logic [DW-1:0]    m_fifo [$];
  logic             m_ovf  = 1'b0;
  logic             m_perr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [WIDTH-1:0] s,
                            input logic r, input logic c, input logic rn);
    logic [DW-1:0] word;
    logic          par;
    if (!rn || c) begin
      m_syms.delete();
      m_fifo.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end else begin
      if (m_fifo.size() != 0 && r) void'(m_fifo.pop_front());
      if (v) begin
        m_syms.push_back(s);
        if (m_syms.size() == FRAME) begin
          word = '0;
          for (int i = 0; i < N; i++) word[i*WIDTH +: WIDTH] = m_syms[i];
          par = 1'b0;
          for (int i = 0; i < DW; i++) par = par ^ word[i];
          if (FRAME > N && m_syms[N][0] != par) m_perr = 1'b1;
          else if (m_fifo.size() < 2) m_fifo.push_back(word);
          else m_ovf = 1'b1;
          m_syms.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_vld",  32'(bus.out_vld),  32'(m_fifo.size() != 0));
    chk("out_word", 32'(bus.out_word), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
    chk("busy",     32'(bus.busy),     32'(m_syms.size() != 0));
    chk("ovf",      32'(bus.ovf),      32'(m_ovf));
    chk("perr",     32'(bus.perr),     32'(m_perr));
  endtask

  // Drive one cycle of inputs, let the edge happen, update model, compare.
  task automatic step(input logic v, input logic [WIDTH-1:0] s,
                      input logic r, input logic c, input logic rn);
    bus.in_vld  = v;
    bus.in_sym  = s;
    bus.out_rdy = r;
    bus.clr     = c;
    rstn        = rn;
    @(posedge clk);
    model_edge(v, s, r, c, rn);
    #1;
    check_all();
  endtask

  task automatic idle(input logic r);
    step(1'b0, '0, r, 1'b0, 1'b1);
  endtask

  // Sends one frame of word w (correct parity symbol appended in the parity
  // build); rdy_last is the out_rdy value on the frame's final symbol.
  task automatic send_word(input logic [DW-1:0] w, input logic rdy, input logic rdy_last);
    logic [WIDTH-1:0] ps;
    for (int i = 0; i < N; i++)
      step(1'b1, w[i*WIDTH +: WIDTH], (i == FRAME - 1) ? rdy_last : rdy, 1'b0, 1'b1);
    if (FRAME > N) begin
      ps = WIDTH'(^w);
      step(1'b1, ps, rdy_last, 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    // Reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_word", 32'(bus.out_word), 32'd0);

    // Symbols 1,0,1,1 separated by idle cycles, consumer always ready
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); idle(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1); idle(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); idle(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    if (FRAME > N) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t1_vld", 32'(bus.out_vld), 32'd1);
    chk("t1_word", 32'(bus.out_word), 32'hD);
    idle(1'b1);
    chk("t1_vld_pulse", 32'(bus.out_vld), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);

    // Overflow: 3 and 5 buffered, 9 dropped
    send_word(4'h3, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    send_word(4'h9, 1'b0, 1'b0);
    chk("t2_head", 32'(bus.out_word), 32'h3);
    chk("t2_ovf", 32'(bus.ovf), 32'd1);
    idle(1'b1);
    chk("t2_second", 32'(bus.out_word), 32'h5);
    idle(1'b1);
    chk("t2_empty", 32'(bus.out_vld), 32'd0);
    chk("t2_ovf_sticky", 32'(bus.ovf), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t2_ovf_clr", 32'(bus.ovf), 32'd0);

    // Push into full buffer while head is popped
    send_word(4'h3, 1'b0, 1'b0);
    send_word(4'h5, 1'b0, 1'b0);
    send_word(4'hA, 1'b0, 1'b1);
    chk("t3_ovf", 32'(bus.ovf), 32'd0);
    chk("t3_head", 32'(bus.out_word), 32'h5);
    idle(1'b1);
    chk("t3_last", 32'(bus.out_word), 32'hA);
    idle(1'b1);
    chk("t3_empty", 32'(bus.out_vld), 32'd0);

    // Flush a partial word
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    send_word(4'b1000, 1'b0, 1'b0);
    chk("t4_word", 32'(bus.out_word), 32'h8);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_ovf", 32'(bus.ovf), 32'd0);

    // Reset mid-word with one word buffered
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_vld", 32'(bus.out_vld), 32'd0);
    chk("t5_word", 32'(bus.out_word), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    send_word(4'h6, 1'b0, 1'b0);
    chk("t5_reassembled", 32'(bus.out_word), 32'h6);
    idle(1'b1);

`ifdef SREG_DESER_PARITY_EN
    // Bad parity symbol: word discarded
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("par_vld", 32'(bus.out_vld), 32'd0);
    chk("par_perr", 32'(bus.perr), 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
`endif

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 3) != 0, WIDTH'($urandom), ($urandom % 2) == 0,
           ($urandom % 150) == 0, ($urandom % 300) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
